// File: rtl/cpu_bus_serializer.sv
// cpu_bus_serializer: CPU parallel bus to narrow pin bus bridge.
// Requests go out as address, command and data beats, LSB beat first.
module cpu_bus_serializer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int PIN_W      = 8,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              busy,
  output logic [PIN_W-1:0]  pin_out,
  output logic [PIN_W-1:0]  pin_oe,
  input  logic [PIN_W-1:0]  pin_in,
  output logic              pin_strobe,
  input  logic              pin_wait
);

  localparam int A   = (ADDR_W + PIN_W - 1) / PIN_W;
  localparam int D   = (DATA_W + PIN_W - 1) / PIN_W;
  localparam int MX0 = (A > D) ? A : D;
  localparam int MX  = (MX0 > TURNAROUND) ? MX0 : TURNAROUND;
  localparam int CW  = $clog2(MX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CMD,
    S_WDATA,
    S_TURN,
    S_RDATA,
    S_DONE
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;
  logic                 we_q;
  logic [A*PIN_W-1:0]   addr_q;
  logic [D*PIN_W-1:0]   wdata_q;
  logic [D*PIN_W-1:0]   rbuf;
  logic [D*PIN_W-1:0]   rbuf_nxt;
  logic [PIN_W-1:0]     addr_beat_nxt;
  logic [PIN_W-1:0]     wdata_beat_nxt;
  logic [PIN_W-1:0]     wdata_beat_0;

  function automatic logic [PIN_W-1:0] addr_sel(
    input logic [A*PIN_W-1:0] v,
    input logic [CW-1:0]      idx
  );
    logic [PIN_W-1:0] r;
    r = '0;
    for (int i = 0; i < A; i++)
      if (int'(idx) == i) r = v[i*PIN_W +: PIN_W];
    return r;
  endfunction

  function automatic logic [PIN_W-1:0] data_sel(
    input logic [D*PIN_W-1:0] v,
    input logic [CW-1:0]      idx
  );
    logic [PIN_W-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++)
      if (int'(idx) == i) r = v[i*PIN_W +: PIN_W];
    return r;
  endfunction

  assign busy = (state != S_IDLE);

  // Next beat selection and read-lane merge for the current counter.
  always_comb begin
    cnt_inc        = cnt + 1'b1;
    addr_beat_nxt  = addr_sel(addr_q, cnt_inc);
    wdata_beat_nxt = data_sel(wdata_q, cnt_inc);
    wdata_beat_0   = data_sel(wdata_q, '0);
    rbuf_nxt       = rbuf;
    for (int i = 0; i < D; i++)
      if (int'(cnt) == i) rbuf_nxt[i*PIN_W +: PIN_W] = pin_in;
  end

  // Transfer sequencer; every pin output is registered for its own beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf       <= '0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      pin_out    <= '0;
      pin_oe     <= '0;
      pin_strobe <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cpu_req) begin
            state      <= S_ADDR;
            cnt        <= '0;
            we_q       <= cpu_we;
            addr_q     <= (A*PIN_W)'(cpu_addr);
            wdata_q    <= (D*PIN_W)'(cpu_wdata);
            pin_out    <= PIN_W'(cpu_addr);
            pin_oe     <= '1;
            pin_strobe <= 1'b1;
          end else begin
            pin_out    <= '0;
            pin_oe     <= '0;
            pin_strobe <= 1'b0;
          end
        end
        S_ADDR: begin
          if (int'(cnt) == A - 1) begin
            state   <= S_CMD;
            cnt     <= '0;
            pin_out <= PIN_W'(we_q);
          end else begin
            cnt     <= cnt_inc;
            pin_out <= addr_beat_nxt;
          end
        end
        S_CMD: begin
          cnt <= '0;
          if (we_q) begin
            state   <= S_WDATA;
            pin_out <= wdata_beat_0;
          end else if (TURNAROUND > 0) begin
            state      <= S_TURN;
            pin_out    <= '0;
            pin_oe     <= '0;
            pin_strobe <= 1'b0;
          end else begin
            state   <= S_RDATA;
            pin_out <= '0;
            pin_oe  <= '0;
          end
        end
        S_WDATA: begin
          if (!pin_wait) begin
            if (int'(cnt) == D - 1) begin
              state      <= S_DONE;
              cnt        <= '0;
              cpu_ack    <= 1'b1;
              pin_out    <= '0;
              pin_oe     <= '0;
              pin_strobe <= 1'b0;
            end else begin
              cnt     <= cnt_inc;
              pin_out <= wdata_beat_nxt;
            end
          end
        end
        S_TURN: begin
          if (int'(cnt) == TURNAROUND - 1) begin
            state      <= S_RDATA;
            cnt        <= '0;
            pin_strobe <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_RDATA: begin
          if (!pin_wait) begin
            rbuf <= rbuf_nxt;
            if (int'(cnt) == D - 1) begin
              state      <= S_DONE;
              cnt        <= '0;
              cpu_ack    <= 1'b1;
              cpu_rdata  <= rbuf_nxt[DATA_W-1:0];
              pin_strobe <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          cnt        <= '0;
          pin_out    <= '0;
          pin_oe     <= '0;
          pin_strobe <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_serializer.sv
// Bench for cpu_bus_serializer: random transfers against a queue scoreboard,
// plus a directed narrow-width instance with zero turnaround.
module tb_cpu_bus_serializer;

  localparam int A    = 4;
  localparam int D    = 4;
  localparam int TURN = 1;

  logic        clk = 0;
  logic        rst = 1;
  logic        cpu_req = 0;
  logic        cpu_we = 0;
  logic [31:0] cpu_addr = 0;
  logic [31:0] cpu_wdata = 0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        busy;
  logic [7:0]  pin_out;
  logic [7:0]  pin_oe;
  logic [7:0]  pin_in = 0;
  logic        pin_strobe;
  logic        pin_wait = 0;

  logic        req2 = 0;
  logic        we2 = 0;
  logic [11:0] addr2 = 0;
  logic [11:0] wdata2 = 0;
  logic [11:0] rdata2;
  logic        ack2;
  logic        busy2;
  logic [7:0]  pin_out2;
  logic [7:0]  pin_oe2;
  logic [7:0]  pin_in2 = 0;
  logic        strobe2;
  logic        wait2 = 0;

  cpu_bus_serializer dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .busy(busy),
    .pin_out(pin_out), .pin_oe(pin_oe), .pin_in(pin_in),
    .pin_strobe(pin_strobe), .pin_wait(pin_wait)
  );

  cpu_bus_serializer #(
    .ADDR_W(12), .DATA_W(12), .PIN_W(8), .TURNAROUND(0)
  ) dut2 (
    .clk(clk), .rst(rst),
    .cpu_req(req2), .cpu_we(we2),
    .cpu_addr(addr2), .cpu_wdata(wdata2),
    .cpu_rdata(rdata2), .cpu_ack(ack2), .busy(busy2),
    .pin_out(pin_out2), .pin_oe(pin_oe2), .pin_in(pin_in2),
    .pin_strobe(strobe2), .pin_wait(wait2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t       txq[$];
  logic [7:0] devq[$];
  bit         wait_en = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         acks = 0;
  bit         t5_done = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] beat(input logic [31:0] v, input int i);
    return 8'(v >> (8 * i));
  endfunction

  // Device model: supplies queued read bytes, random stalls and garbage.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pin_wait = wait_en && ($urandom_range(0, 3) == 0);
      if (pin_strobe && pin_oe == 8'h00 && !pin_wait && devq.size() > 0)
        pin_in = devq.pop_front();
      else
        pin_in = 8'($urandom);
    end
  end

  // Monitor: pops the scoreboard as beats and acks appear.
  initial begin
    int   bidx;
    int   stalls;
    int   rel;
    int   lat;
    bit   prst;
    logic [31:0] last_rd;
    txn_t t;
    bidx = 0; stalls = 0; prst = 1; last_rd = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        txq.delete();
        bidx = 0;
        stalls = 0;
        prst = 1;
        continue;
      end
      if (prst) begin
        chk("reset_oe", pin_oe, 0);
        chk("reset_strobe", pin_strobe, 0);
        chk("reset_out", pin_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ack", cpu_ack, 0);
        chk("reset_rdata", cpu_rdata, 0);
        last_rd = 0;
        prst = 0;
      end
      if (txq.size() == 0) begin
        chk("idle_ack", cpu_ack, 0);
        chk("idle_strobe", pin_strobe, 0);
        continue;
      end
      t = txq[0];
      rel = cyc - t.acc;
      if (rel <= 0) continue;
      chk("busy", busy, 1);
      if (pin_strobe) begin
        if (bidx < A) begin
          chk("addr_beat", {pin_oe, pin_out}, {8'hFF, beat(t.addr, bidx)});
          bidx++;
        end else if (bidx == A) begin
          chk("cmd_beat", {pin_oe, pin_out}, {8'hFF, 7'b0, t.we});
          bidx++;
        end else if (bidx < A + 1 + D) begin
          if (t.we)
            chk("wdata_beat", {pin_oe, pin_out},
                {8'hFF, beat(t.wdata, bidx - A - 1)});
          else
            chk("rdata_oe", pin_oe, 0);
          if (pin_wait) stalls++;
          else bidx++;
        end else begin
          chk("extra_strobe", pin_strobe, 0);
        end
      end else begin
        chk("quiet_oe", pin_oe, 0);
      end
      if (cpu_ack) begin
        lat = (t.we ? A + D + 2 : A + TURN + D + 2) + stalls;
        chk("ack_latency", rel, lat);
        chk("beat_count", bidx, A + 1 + D);
        if (!t.we) last_rd = t.rdata;
        chk("cpu_rdata", cpu_rdata, last_rd);
        void'(txq.pop_front());
        bidx = 0;
        stalls = 0;
        acks++;
      end
    end
  end

  task automatic issue(input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold,
                       output bit ok);
    txn_t       t;
    logic [7:0] b;
    int         start;
    int         n;
    t.acc = cyc; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = 0;
    if (!we)
      for (int i = 0; i < D; i++) begin
        b = 8'($urandom);
        devq.push_back(b);
        t.rdata |= 32'(b) << (8 * i);
      end
    txq.push_back(t);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    start = acks;
    @(posedge clk); #1;
    if (!hold) cpu_req = 0;
    cpu_addr = $urandom;
    cpu_wdata = $urandom;
    cpu_we = 1'($urandom);
    n = 0;
    while (acks == start && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (acks != start);
    if (!ok) begin
      miscompares++;
      vectors++;
      $display("FAIL ack_timeout: no ack after %0d cycles", n);
    end
  endtask

  // Main stimulus.
  initial begin
    bit ok;
    int gap;
    ok = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
    issue(1, 32'h12345678, 32'hAABBCCDD, 0, ok);
    if (ok) issue(0, 32'h00000010, 32'h0, 0, ok);
    wait_en = 1;
    if (ok) issue(0, 32'hCAFE0004, 32'h0, 0, ok);
    wait_en = 0;
    if (ok) issue(1, 32'h0000BEEF, 32'h01020304, 1, ok);
    if (ok) issue(1, 32'h00FF00FF, 32'h55667788, 1, ok);
    cpu_req = 0;
    if (ok) begin
      txq.push_back('{acc: cyc, we: 1'b1, addr: 32'h11111111,
                      wdata: 32'h22222222, rdata: 32'h0});
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h11111111;
      cpu_wdata = 32'h22222222;
      @(posedge clk); #1;
      cpu_req = 0;
      repeat (A + 2) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      devq.delete();
      repeat (2) @(posedge clk);
      #1;
      issue(0, 32'h87654321, 32'h0, 0, ok);
    end
    wait_en = 1;
    for (int k = 0; k < 40 && ok; k++) begin
      issue(1'($urandom), $urandom, $urandom, 1'($urandom), ok);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        cpu_req = 0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    cpu_req = 0;
    wait_en = 0;
    repeat (4) @(posedge clk);
    #1;
    if (!t5_done) begin
      miscompares++;
      vectors++;
      $display("FAIL t5_incomplete: narrow instance check did not finish");
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  // Narrow instance: 12-bit address/data, zero turnaround, one read.
  initial begin
    logic [7:0] eoe [6];
    logic       est [6];
    logic       eack [6];
    logic [7:0] eout [3];
    eoe  = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    est  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    eack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    eout = '{8'hBC, 8'h0A, 8'h00};
    wait (rst == 1'b0);
    @(posedge clk); #1;
    req2 = 1; we2 = 0; addr2 = 12'hABC;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      req2 = 0;
      addr2 = 12'h123;
      pin_in2 = (k == 4) ? 8'hF5 : (k == 5) ? 8'hE7 : 8'h3C;
      @(negedge clk);
      chk("t5_oe", pin_oe2, eoe[k-1]);
      chk("t5_strobe", strobe2, est[k-1]);
      chk("t5_ack", ack2, eack[k-1]);
      if (k <= 3) chk("t5_out", pin_out2, eout[k-1]);
      if (k == 6) chk("t5_rdata", rdata2, 12'h7F5);
    end
    @(negedge clk);
    chk("t5_idle_busy", busy2, 0);
    chk("t5_idle_ack", ack2, 0);
    t5_done = 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
